// File: rtl/mul_of_three_pkg.sv
// mul_of_three_pkg
// Shared definitions for the serial divisibility-by-three detector.
//   state_t   : 3-bit state {parity, rem[1:0]}, six legal encodings E0..O2
//   PARITY_POS, REM_HI, REM_LO : bit positions of the state fields
//   mod3_add  : (a + b) mod 3 for residues a, b in 0..2
//   is_legal  : 1 for the six legal encodings (rem field never 2'b11)
package mul_of_three_pkg;

    typedef enum logic [2:0] {
        E0 = 3'b000,
        E1 = 3'b001,
        E2 = 3'b010,
        O0 = 3'b100,
        O1 = 3'b101,
        O2 = 3'b110
    } state_t;

    localparam int PARITY_POS = 2;
    localparam int REM_HI     = 1;
    localparam int REM_LO     = 0;

    // Both operands are residues (0..2), so the sum is at most 4 and a
    // single conditional subtract is enough.
    function automatic logic [1:0] mod3_add(input logic [1:0] rem, input logic [1:0] w);
        logic [2:0] sum;
        sum = {1'b0, rem} + {1'b0, w};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    function automatic logic is_legal(input logic [2:0] s);
        return s[REM_HI:REM_LO] != 2'b11;
    endfunction

endpackage

// File: rtl/mul_of_three.sv
// mul_of_three
// Serial divisibility-by-three detector. One bit is consumed on every rising
// clock edge; out is high whenever the value built from all bits received
// since reset is a multiple of 3. Only the residue is tracked, so streams of
// any length are handled.
//
// Parameters:
//   LSB_FIRST : 1 = first bit has weight 2^0; 0 = first bit is the MSB
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset (forces state E0, out = 1)
//   inp       : serial data bit, sampled every rising edge
//   out       : Moore output, 1 when accumulated value mod 3 == 0
// Optional (build with MUL_OF_THREE_STATE_DBG_EN defined):
//   state_dbg : copy of the internal state register
//   bit_cnt   : consumed-bit counter, saturates at 16'hFFFF, cleared by reset
module mul_of_three
    import mul_of_three_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inp,
`ifdef MUL_OF_THREE_STATE_DBG_EN
    output logic [2:0]  state_dbg,
    output logic [15:0] bit_cnt,
`endif
    output logic        out
);

    state_t     state;
    state_t     state_next;
    logic       parity;
    logic [1:0] rem;
    logic [1:0] weight;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= E0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Illegal encodings fall through to E0.
    always_comb begin
        state_next = E0;
        parity     = state[PARITY_POS];
        rem        = state[REM_HI:REM_LO];
        weight     = 2'd0;
        if (is_legal(state)) begin
            if (LSB_FIRST) begin
                // 2^n mod 3 alternates 1, 2, 1, 2 ... with the bit position.
                weight     = parity ? 2'd2 : 2'd1;
                state_next = state_t'({~parity, mod3_add(rem, inp ? weight : 2'd0)});
            end else begin
                // Shift-left-and-add: rem' = (2*rem + inp) mod 3, parity unused.
                state_next = state_t'({1'b0, mod3_add(mod3_add(rem, rem), {1'b0, inp})});
            end
        end
    end

    // Output decode from state only.
    always_comb begin
        out = is_legal(state) && (state[REM_HI:REM_LO] == 2'b00);
    end

`ifdef MUL_OF_THREE_STATE_DBG_EN
    logic [15:0] bit_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_reg <= 16'd0;
        end else if (bit_cnt_reg != 16'hFFFF) begin
            bit_cnt_reg <= bit_cnt_reg + 16'd1;
        end
    end

    assign state_dbg = state;
    assign bit_cnt   = bit_cnt_reg;
`endif

endmodule

// File: tb/tb_mul_of_three.sv
// tb_mul_of_three
// Self-checking bench for mul_of_three. Two instances share clock and reset:
// one LSB-first, one MSB-first. Directed vectors come from a table of
// {bits, expected out per edge, expected final state}; random streams are
// checked against a model that accumulates the numeric value directly.
module tb_mul_of_three;
    import mul_of_three_pkg::*;

    logic clk;
    logic reset;
    logic inp_lsb;
    logic inp_msb;
    logic out_lsb;
    logic out_msb;
`ifdef MUL_OF_THREE_STATE_DBG_EN
    logic [2:0]  state_dbg_lsb;
    logic [15:0] bit_cnt_lsb;
    logic [2:0]  state_dbg_msb;
    logic [15:0] bit_cnt_msb;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mul_of_three #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .inp       (inp_lsb),
`ifdef MUL_OF_THREE_STATE_DBG_EN
        .state_dbg (state_dbg_lsb),
        .bit_cnt   (bit_cnt_lsb),
`endif
        .out       (out_lsb)
    );

    mul_of_three #(.LSB_FIRST(1'b0)) dut_msb (
        .clk       (clk),
        .reset     (reset),
        .inp       (inp_msb),
`ifdef MUL_OF_THREE_STATE_DBG_EN
        .state_dbg (state_dbg_msb),
        .bit_cnt   (bit_cnt_msb),
`endif
        .out       (out_msb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          msb;        // 1: MSB-first instance
        int          n;          // number of bits
        logic [15:0] bits;       // bit i is fed at edge i+1
        logic [15:0] exp_out;    // bit i is out after edge i+1
        logic [2:0]  exp_final;  // state after last edge
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_out(input bit msb);
        return msb ? out_msb : out_lsb;
    endfunction

    function automatic logic [2:0] get_state(input bit msb);
        return msb ? 3'(dut_msb.state) : 3'(dut_lsb.state);
    endfunction

    // Apply reset (async), check reset values without a clock edge, then
    // release at a falling edge so the next rising edge takes bit 0.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        inp_lsb = 1'b0;
        inp_msb = 1'b0;
        #2;
        chk({tag, " rst out_lsb"}, 32'(out_lsb), 32'd1);
        chk({tag, " rst state_lsb"}, 32'(get_state(1'b0)), 32'(E0));
        chk({tag, " rst out_msb"}, 32'(out_msb), 32'd1);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic feed(input bit msb, input logic b);
        if (msb) inp_msb = b;
        else     inp_lsb = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        longint unsigned val;
        int              len;
        logic            b;
        logic [2:0]      exp_state;

        reset   = 1'b0;
        inp_lsb = 1'b0;
        inp_msb = 1'b0;

        //            msb  n   bits            exp_out     final
        vecs[0] = '{1'b0,  2, 16'b11,         16'b10,      3'b000}; // 3
        vecs[1] = '{1'b0,  2, 16'b10,         16'b01,      3'b010}; // 2
        vecs[2] = '{1'b0,  3, 16'b101,        16'b000,     3'b110}; // 5
        vecs[3] = '{1'b0, 16, 16'h38B8,       16'hE817,    3'b000}; // 14520
        vecs[4] = '{1'b1,  3, 16'b011,        16'b110,     3'b000}; // 6, MSB first

        #12;
        do_reset("init");

        // Table-driven directed vectors
        for (int v = 0; v < 5; v++) begin
            do_reset($sformatf("vec%0d", v));
            for (int i = 0; i < vecs[v].n; i++) begin
                feed(vecs[v].msb, vecs[v].bits[i]);
                chk($sformatf("vec%0d out edge%0d", v, i + 1),
                    32'(get_out(vecs[v].msb)), 32'(vecs[v].exp_out[i]));
            end
            chk($sformatf("vec%0d final state", v),
                32'(get_state(vecs[v].msb)), 32'(vecs[v].exp_final));
`ifdef MUL_OF_THREE_STATE_DBG_EN
            if (v == 3) begin
                chk("bit_cnt after 16 bits", 32'(bit_cnt_lsb), 32'd16);
                chk("state_dbg after 16 bits", 32'(state_dbg_lsb), 32'(E0));
            end
`endif
        end

        // First edge after LSB value 3: O1
        do_reset("o1");
        feed(1'b0, 1'b1);
        chk("lsb state after bit 1", 32'(get_state(1'b0)), 32'(O1));

        // Mid-stream asynchronous reset after bits 1,0
        do_reset("mid");
        feed(1'b0, 1'b1);
        feed(1'b0, 1'b0);
        chk("mid pre-reset out", 32'(out_lsb), 32'd0);
        chk("mid pre-reset state", 32'(get_state(1'b0)), 32'(E1));
        #2;
        reset = 1'b0;
        #1;
        chk("mid async reset out", 32'(out_lsb), 32'd1);
        chk("mid async reset state", 32'(get_state(1'b0)), 32'(E0));
        @(negedge clk);
        reset = 1'b1;
        feed(1'b0, 1'b1);  // treated as position 0 again -> O1
        chk("mid restart state", 32'(get_state(1'b0)), 32'(O1));

        // Illegal encoding recovery
        do_reset("ill");
        @(negedge clk);
        force dut_lsb.state = state_t'(3'b011);
        #1;
        chk("illegal out", 32'(out_lsb), 32'd0);
        release dut_lsb.state;
        inp_lsb = 1'b1;
        @(posedge clk);
        #1;
        chk("illegal recovery state", 32'(get_state(1'b0)), 32'(E0));

        // Randomized streams against a value-accumulating model
        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < 12; s++) begin
                do_reset($sformatf("rnd m%0d s%0d", m, s));
                val = 0;
                len = $urandom_range(1, 60);
                for (int i = 0; i < len; i++) begin
                    b = 1'($urandom_range(0, 1));
                    if (m == 1) val = val * 2 + longint'(b);
                    else        val = val + (longint'(b) << i);
                    feed(m == 1, b);
                    if (m == 1) exp_state = {1'b0, 2'(val % 3)};
                    else        exp_state = {1'((i + 1) % 2), 2'(val % 3)};
                    chk($sformatf("rnd m%0d s%0d out bit%0d", m, s, i),
                        32'(get_out(m == 1)), 32'(val % 3 == 0));
                    chk($sformatf("rnd m%0d s%0d state bit%0d", m, s, i),
                        32'(get_state(m == 1)), 32'(exp_state));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_of_three.md
# mul_of_three

Serial divisibility-by-three detector. Consumes one input bit per clock and asserts `out` whenever the binary number formed by all bits received since reset is a multiple of 3. Used as a small streaming checker/FSM block in the lab datapath; `state` is a named internal register that benches probe hierarchically.

## Interface

- `LSB_FIRST`, default 1: 1 means the first bit received is bit 0 (weight 2^0). 0 means the first bit is the MSB; each new bit shifts the value left.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset. Low forces the reset state immediately.
- `inp` input 1: serial data bit, sampled on every rising edge. There is no enable; every edge consumes a bit.
- `out` output 1: 1 when the accumulated value mod 3 equals 0.

## Operation

- Internal register `state` is 3 bits wide and holds {parity, rem[1:0]}.
  - `rem` is the accumulated value mod 3.
  - `parity` is the position parity of the next bit: 0 means even position (weight ≡1 mod 3), 1 means odd position (weight ≡2 mod 3).
- Six legal states: E0, E1, E2, O0, O1, O2, encoded 3'b000, 001, 010, 100, 101, 110.
- Reset state is E0. An empty value is 0, so it counts as divisible.
- LSB_FIRST=1 transitions:
  - Er with inp=0 goes to Or.
  - Er with inp=1 goes to O((r+1) mod 3).
  - Or with inp=0 goes to Er.
  - Or with inp=1 goes to E((r+2) mod 3).
- LSB_FIRST=0: rem' = (2·rem + inp) mod 3, and parity is held at 0. Only E0/E1/E2 are reachable.
- Illegal encodings (3'b011, 3'b111) go to E0 on the next edge, and `out`=0 while in them.
- `out` is Moore: `out` = (rem == 0) for legal states. It is decoded from `state` only and never depends combinationally on `inp`.
- Value width is unbounded: only the residue is tracked, so arbitrarily long streams are correct.

## Timing

- Latency: the bit sampled at edge k is reflected in `out` immediately after edge k. The value is valid for the whole following cycle, including at the next falling edge.
- Reset value: `state`=E0 and `out`=1, both asynchronously on `reset` falling.
- Reset release is synchronous-safe: the first edge with `reset` high consumes the first bit.
- Reset mid-stream: the accumulated value is discarded and the next bit is treated as position 0.
- `inp` only needs standard setup/hold around the rising edge. Changes elsewhere in the cycle have no effect.

## Configuration

- `MUL_OF_THREE_STATE_DBG_EN`:
  - Defined: adds output port `state_dbg` [2:0], a direct copy of `state`.
  - Also defined: adds output `bit_cnt` [15:0], which counts consumed bits, saturates at 16'hFFFF, and resets to 0.
  - Not defined: neither port exists, and the behaviour of `out` is identical.

## Structure

- Shared package `mul_of_three_pkg` holds:
  - the state typedef (3-bit enum E0..O2 with the encodings above);
  - localparams for the parity/rem field positions;
  - a pure function `mod3_add(rem, w)`.
- A single module with no sub-module: the next-state logic is a small combinational block next to the state register.

## Test plan

- Reset: hold `reset`=0, then check `state`=E0 and `out`=1. Assert reset mid-stream after bits 1,0 and check `out`=1 and `state`=E0 at once, with no clock edge needed.
- LSB_FIRST=1, bits 1,1 (value 3): after edge 1, `out`=0 and `state`=O1. After edge 2, `out`=1 and `state`=E0.
- LSB_FIRST=1, bits 0,1 (value 2): `out`=1 then 0.
- LSB_FIRST=1, bits 1,0,1 (value 5): `out` sequence 0,0,0.
- LSB_FIRST=1, 16'h38B8 fed bit 0 first:
  - `out` after each of the first 8 edges must be 1,1,1,0,1,0,0,0 (values 0,0,0,8,24,56,56,184).
  - Final `out` after edge 16 must be 1 (14520 = 3·4840).
- LSB_FIRST=0, bits 1,1,0 (value 6): `out` sequence 0,1,1.
- Force an illegal state (3'b011): `out`=0, and after the next edge `state`=E0.
- With `MUL_OF_THREE_STATE_DBG_EN`: `bit_cnt` equals 16 after the 16-bit stream.
